// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared definitions for the iterative RV32M multiply/divide
//                unit: funct3 encodings, FSM state type and the iteration
//                count that fixes the unit's latency.
//  Revision    : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    // funct3 encodings of the RV32M OP instructions
    localparam logic [2:0] c_MUL    = 3'd0;
    localparam logic [2:0] c_MULH   = 3'd1;
    localparam logic [2:0] c_MULHSU = 3'd2;
    localparam logic [2:0] c_MULHU  = 3'd3;
    localparam logic [2:0] c_DIV    = 3'd4;
    localparam logic [2:0] c_DIVU   = 3'd5;
    localparam logic [2:0] c_REM    = 3'd6;
    localparam logic [2:0] c_REMU   = 3'd7;

    // Radix-2 steps per operation; decode-stage hazard logic uses this too
    localparam int c_ITER = 32;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter
//  Description : Radix-2 datapath. Holds the {hi, lo} accumulator and the
//                multiplicand/divisor. Multiply is shift-add (lo starts as
//                the multiplier), divide is restoring shift-subtract (lo
//                starts as the dividend and collects quotient bits, hi is
//                the partial remainder). Operands are unsigned magnitudes.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_step,
    input  logic                i_is_div,
    input  logic [XLEN-1:0]     i_opa,       // multiplicand / dividend
    input  logic [XLEN-1:0]     i_opb,       // multiplier / divisor
    output logic [2*XLEN-1:0]   o_next_acc   // {hi, lo} after the current step
);

    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_d;
    logic            r_is_div;

    logic [XLEN:0]   w_add;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_hi_nxt;
    logic [XLEN-1:0] w_lo_nxt;

    // One radix-2 step of either operation, evaluated every cycle
    always_comb begin
        // multiply: conditionally add multiplicand, then shift {carry,hi,lo} right
        w_add    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : {(XLEN+1){1'b0}});
        // divide: shift next dividend bit into the 33-bit partial remainder
        w_shift  = {r_hi, r_lo[XLEN-1]};
        w_ge     = (w_shift >= {1'b0, r_d});
        // when w_ge holds the true difference is below r_d, so it fits XLEN bits
        w_diff   = w_shift[XLEN-1:0] - r_d;
        if (r_is_div) begin
            w_hi_nxt = w_ge ? w_diff : w_shift[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_hi_nxt = w_add[XLEN:1];
            w_lo_nxt = {w_add[0], r_lo[XLEN-1:1]};
        end
        o_next_acc = {w_hi_nxt, w_lo_nxt};
    end

    // Accumulator: load fresh operands or advance by one step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_d      <= '0;
            r_is_div <= 1'b0;
        end else if (i_load) begin
            r_hi     <= '0;
            r_lo     <= i_is_div ? i_opa : i_opb;
            r_d      <= i_is_div ? i_opb : i_opa;
            r_is_div <= i_is_div;
        end else if (i_step) begin
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
        end
    end

endmodule : muldiv_iter
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide unit. Accepts one request
//                while idle, iterates for ITER cycles, then issues a single
//                registered writeback strobe. Handles operand signedness,
//                result sign correction, divide-by-zero and flush.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = c_ITER
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcreg1_value,
    input  logic [XLEN-1:0] srcreg2_value,
    input  logic [4:0]      dstreg_num,
    output logic            busy,
    output logic            we,
    output logic [4:0]      wb_dstreg_num,
    output logic [XLEN-1:0] wb_dstreg_value
);

    localparam int            CW     = $clog2(ITER);
    localparam logic [CW-1:0] c_LAST = CW'(ITER - 1);

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rd;
    logic            r_neg_res;    // product / quotient must be negated
    logic            r_neg_rem;    // remainder must be negated
    logic            r_div0;
    logic [XLEN-1:0] r_dividend;   // raw rs1, returned as REM on divide by zero

    logic            w_s1_signed;
    logic            w_s2_signed;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_load;
    logic            w_step;
    logic [2*XLEN-1:0] w_next;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0] w_quo_s;
    logic [XLEN-1:0] w_rem_s;
    logic [XLEN-1:0] w_result;

    // Operand signedness and magnitudes from the incoming request
    always_comb begin
        w_s1_signed = 1'b0;
        w_s2_signed = 1'b0;
        case (funct3)
            c_MUL, c_MULH, c_DIV, c_REM: begin
                w_s1_signed = 1'b1;
                w_s2_signed = 1'b1;
            end
            c_MULHSU: w_s1_signed = 1'b1;
            default: ;
        endcase
        w_neg_a = w_s1_signed & srcreg1_value[XLEN-1];
        w_neg_b = w_s2_signed & srcreg2_value[XLEN-1];
        // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude
        w_mag_a = w_neg_a ? -srcreg1_value : srcreg1_value;
        w_mag_b = w_neg_b ? -srcreg2_value : srcreg2_value;
    end

    assign w_load = (r_state == IDLE) && start && !flush;
    assign w_step = (r_state == CALC) && !flush;

    muldiv_iter #(
        .XLEN       (XLEN)
    ) u_iter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_is_div   (funct3[2]),
        .i_opa      (w_mag_a),
        .i_opb      (w_mag_b),
        .o_next_acc (w_next)
    );

    // Sign correction and result selection from the final step's value.
    // Signed overflow needs no special case: |0x80000000| / 1 gives
    // 0x80000000 with a positive sign and a zero remainder.
    always_comb begin
        w_prod_s = r_neg_res ? -w_next : w_next;
        w_quo_s  = r_neg_res ? -w_next[XLEN-1:0] : w_next[XLEN-1:0];
        w_rem_s  = r_neg_rem ? -w_next[2*XLEN-1:XLEN] : w_next[2*XLEN-1:XLEN];
        case (r_funct3)
            c_MUL:                     w_result = w_prod_s[XLEN-1:0];
            c_MULH, c_MULHSU, c_MULHU: w_result = w_prod_s[2*XLEN-1:XLEN];
            c_DIV, c_DIVU:             w_result = r_div0 ? {XLEN{1'b1}} : w_quo_s;
            default:                   w_result = r_div0 ? r_dividend : w_rem_s;
        endcase
    end

    // Control FSM with registered writeback outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_count         <= '0;
            r_funct3        <= 3'd0;
            r_rd            <= 5'd0;
            r_neg_res       <= 1'b0;
            r_neg_rem       <= 1'b0;
            r_div0          <= 1'b0;
            r_dividend      <= '0;
            busy            <= 1'b0;
            we              <= 1'b0;
            wb_dstreg_num   <= 5'd0;
            wb_dstreg_value <= '0;
        end else if (flush) begin
            // redirect kills any in-flight work and a same-cycle start
            r_state <= IDLE;
            r_count <= '0;
            busy    <= 1'b0;
            we      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    we <= 1'b0;
                    if (start) begin
                        r_state    <= CALC;
                        r_count    <= '0;
                        r_funct3   <= funct3;
                        r_rd       <= dstreg_num;
                        r_neg_res  <= w_neg_a ^ w_neg_b;
                        r_neg_rem  <= w_neg_a;
                        r_div0     <= (srcreg2_value == '0);
                        r_dividend <= srcreg1_value;
                        busy       <= 1'b1;
                    end
                end
                CALC: begin
                    r_count <= r_count + 1'b1;
                    if (r_count == c_LAST) begin
                        r_state <= DONE;
                        r_count <= '0;
                        we      <= (r_rd != 5'd0);
                        if (r_rd != 5'd0) begin
                            wb_dstreg_num   <= r_rd;
                            wb_dstreg_value <= w_result;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    we      <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    we      <= 1'b0;
                end
            endcase
        end
    end

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed self-checking bench for muldiv_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] srcreg1_value;
    logic [31:0] srcreg2_value;
    logic [4:0]  dstreg_num;
    logic        busy;
    logic        we;
    logic [4:0]  wb_dstreg_num;
    logic [31:0] wb_dstreg_value;

    int checks   = 0;
    int failures = 0;

    muldiv_unit dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .flush           (flush),
        .funct3          (funct3),
        .srcreg1_value   (srcreg1_value),
        .srcreg2_value   (srcreg2_value),
        .dstreg_num      (dstreg_num),
        .busy            (busy),
        .we              (we),
        .wb_dstreg_num   (wb_dstreg_num),
        .wb_dstreg_value (wb_dstreg_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation, expect the strobe 32 edges after the accept edge
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int lat;
        lat = -1;
        @(negedge clk);
        start = 1'b1; funct3 = f3; srcreg1_value = a; srcreg2_value = b; dstreg_num = rd;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (we) begin
                lat = i;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'd32);
        chk({tag, " rd"}, 32'(wb_dstreg_num), 32'(rd));
        chk({tag, " value"}, wb_dstreg_value, exp);
        @(posedge clk); #1;
        chk({tag, " we_one_cycle"}, 32'(we), 32'd0);
        chk({tag, " busy_released"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int busy_cnt;
        int we_cnt;
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0;
        srcreg1_value = 32'd0; srcreg2_value = 32'd0; dstreg_num = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset we", 32'(we), 32'd0);
        chk("reset rd", 32'(wb_dstreg_num), 32'd0);
        chk("reset value", wb_dstreg_value, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Multiply family
        run_op("MUL",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB);
        run_op("MULH",   3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000);
        run_op("MULHU",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE);
        run_op("MULHSU", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF);
        run_op("MULbig", 3'd0, 32'd100000,   32'd300000,   5'd31, 32'hFC23AC00);

        // Divide family, including divide-by-zero and signed overflow
        run_op("DIV",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD);
        run_op("REM",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF);
        run_op("DIVU",   3'd5, 32'd100,      32'd7,        5'd12, 32'd14);
        run_op("REMU",   3'd7, 32'd100,      32'd7,        5'd13, 32'd2);
        run_op("DIVU0",  3'd5, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF);
        run_op("REMU0",  3'd7, 32'd5,        32'd0,        5'd15, 32'd5);
        run_op("DIV0s",  3'd4, 32'hFFFFFFF9, 32'd0,        5'd16, 32'hFFFFFFFF);
        run_op("DIVovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000);
        run_op("REMovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0);

        // rd=0: busy for the full operation, no strobe; second start ignored
        busy_cnt = 0; we_cnt = 0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; srcreg1_value = 32'd3; srcreg2_value = 32'd4; dstreg_num = 5'd0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (we) we_cnt++;
            if (i == 0) dstreg_num = 5'd9;
            if (i == 5) start = 1'b0;
        end
        chk("rd0 busy_cycles", 32'(busy_cnt), 32'd33);
        chk("rd0 no_we", 32'(we_cnt), 32'd0);

        // flush at count=10
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; srcreg1_value = 32'd3; srcreg2_value = 32'd4; dstreg_num = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy", 32'(busy), 32'd0);
        we_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (we) we_cnt++;
        end
        chk("flush no_we", 32'(we_cnt), 32'd0);

        // start together with flush is dropped
        @(negedge clk);
        start = 1'b1; flush = 1'b1; dstreg_num = 5'd4;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("start_flush busy", 32'(busy), 32'd0);
        we_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (we) we_cnt++;
        end
        chk("start_flush no_we", 32'(we_cnt), 32'd0);

        // asynchronous reset mid-CALC clears outputs at once
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; srcreg1_value = 32'd9; srcreg2_value = 32'd9; dstreg_num = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst busy", 32'(busy), 32'd0);
        chk("async_rst we", 32'(we), 32'd0);
        chk("async_rst rd", 32'(wb_dstreg_num), 32'd0);
        chk("async_rst value", wb_dstreg_value, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", 3'd0, 32'd6, 32'd7, 5'd21, 32'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_muldiv_unit
`default_nettype wire
